// File: rtl/trakball_pkg.sv
// Shared types and helpers for the trackball emulator: pending-count width, limits
// and the saturating accumulate used by each axis.
package trakball_pkg;

    localparam int unsigned PEND_W   = 10;
    localparam int          PEND_MAX = 511;
    localparam int unsigned CNT_W    = 4;

    typedef logic signed [PEND_W-1:0] pend_t;

    // Delta is one bit wider than the mouse field so that -(-256) survives the y negation.
    typedef struct packed {
        logic  valid;
        pend_t delta;
    } mouse_add_t;

    function automatic pend_t sat_add(input int a, input int b);
        int    s;
        pend_t r;
        s = a + b;
        if (s > PEND_MAX) begin
            r = pend_t'(PEND_MAX);
        end else if (s < -PEND_MAX) begin
            r = pend_t'(-PEND_MAX);
        end else begin
            r = pend_t'(s);
        end
        return r;
    endfunction

endpackage

// File: rtl/trak_axis.sv
// One trackball axis: joystick speed ramp, signed pending accumulator and the
// 4-bit wrapping counter/direction pair that is drained once per tick.
module trak_axis
    import trakball_pkg::*;
#(
    parameter int unsigned SPEED_MAX  = 8,
    parameter int unsigned RAMP_TICKS = 64
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             tick,
    input  logic             joy_pos,
    input  logic             joy_neg,
    input  mouse_add_t       mouse_add,
    output logic [CNT_W-1:0] cnt,
    output logic             dir
);

    localparam int unsigned SPD_W  = $clog2(SPEED_MAX + 1);
    localparam int unsigned RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

    logic [SPD_W-1:0]  speed_q, speed_d;
    logic [RAMP_W-1:0] ramp_q, ramp_d;
    pend_t             pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic              held;
    int                joy_amt, mouse_amt, step;

    always_comb begin
        held      = joy_pos ^ joy_neg;
        speed_d   = speed_q;
        ramp_d    = ramp_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        joy_amt   = 0;
        step      = 0;
        mouse_amt = mouse_add.valid ? int'($signed(mouse_add.delta)) : 0;
        if (tick) begin
            if (held) begin
                joy_amt = joy_pos ? int'(speed_q) : -int'(speed_q);
                if (ramp_q == RAMP_W'(RAMP_TICKS - 1)) begin
                    ramp_d = '0;
                    if (speed_q < SPD_W'(SPEED_MAX)) speed_d = speed_q + 1'b1;
                end else begin
                    ramp_d = ramp_q + 1'b1;
                end
            end else begin
                speed_d = SPD_W'(1);
                ramp_d  = '0;
            end
            if (pend_q > 0) begin
                cnt_d = cnt_q + 1'b1;
                dir_d = 1'b1;
                step  = 1;
            end else if (pend_q < 0) begin
                cnt_d = cnt_q - 1'b1;
                dir_d = 1'b0;
                step  = -1;
            end
        end
        // Mouse, joystick and drain land together and saturate once.
        pend_d = sat_add(int'(pend_q) + mouse_amt, joy_amt - step);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            speed_q <= SPD_W'(1);
            ramp_q  <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            speed_q <= speed_d;
            ramp_q  <= ramp_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    assign cnt = cnt_q;
    assign dir = dir_q;

endmodule

// File: rtl/trakball_emu.sv
// Centipede trackball emulation from joystick directions and PS/2 mouse motion:
// step prescaler, mouse strobe detection, axis mapping and trakball_o packing.
module trakball_emu
    import trakball_pkg::*;
#(
    parameter int unsigned PRESCALE   = 3000,
    parameter int unsigned SPEED_MAX  = 8,
    parameter int unsigned RAMP_TICKS = 64
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             joy_l,
    input  logic             joy_r,
    input  logic             joy_u,
    input  logic             joy_d,
    input  logic             swap_xy,
    input  logic             mouse_strobe,
    input  logic [8:0]       mouse_dx,
    input  logic [8:0]       mouse_dy,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             h_dir,
    output logic             v_dir,
    output logic [7:0]       trakball_o
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick;
    logic             strobe_q, primed_q, mouse_evt;
    mouse_add_t       add_h_q, add_h_d, add_v_q, add_v_d;
    pend_t            dx_ext, ndy_ext;
    logic             h_pos, h_neg, v_pos, v_neg;

    always_comb begin
        tick          = (presc_q == PRE_W'(PRESCALE - 1));
        presc_d       = tick ? '0 : presc_q + 1'b1;
        mouse_evt     = primed_q && (mouse_strobe != strobe_q);
        dx_ext        = {mouse_dx[8], mouse_dx};
        ndy_ext       = -{mouse_dy[8], mouse_dy};
        add_h_d.valid = mouse_evt;
        add_v_d.valid = mouse_evt;
        if (swap_xy) begin
            h_pos         = joy_u;
            h_neg         = joy_d;
            v_pos         = joy_r;
            v_neg         = joy_l;
            add_h_d.delta = ndy_ext;
            add_v_d.delta = dx_ext;
        end else begin
            h_pos         = joy_r;
            h_neg         = joy_l;
            v_pos         = joy_d;
            v_neg         = joy_u;
            add_h_d.delta = dx_ext;
            add_v_d.delta = ndy_ext;
        end
    end

    // The first cycle out of reset only captures the strobe level.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            strobe_q <= 1'b0;
            primed_q <= 1'b0;
            add_h_q  <= '0;
            add_v_q  <= '0;
        end else begin
            presc_q  <= presc_d;
            strobe_q <= mouse_strobe;
            primed_q <= 1'b1;
            add_h_q  <= add_h_d;
            add_v_q  <= add_v_d;
        end
    end

    trak_axis #(
        .SPEED_MAX (SPEED_MAX),
        .RAMP_TICKS(RAMP_TICKS)
    ) u_axis_h (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .tick     (tick),
        .joy_pos  (h_pos),
        .joy_neg  (h_neg),
        .mouse_add(add_h_q),
        .cnt      (h_cnt),
        .dir      (h_dir)
    );

    trak_axis #(
        .SPEED_MAX (SPEED_MAX),
        .RAMP_TICKS(RAMP_TICKS)
    ) u_axis_v (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .tick     (tick),
        .joy_pos  (v_pos),
        .joy_neg  (v_neg),
        .mouse_add(add_v_q),
        .cnt      (v_cnt),
        .dir      (v_dir)
    );

    assign trakball_o = {v_dir, v_cnt[2:0], h_dir, h_cnt[2:0]};

endmodule

// File: tb/tb_trakball_emu.sv
// Self-checking bench for trakball_emu: directed scenarios plus random traffic,
// compared against a cycle-level arithmetic model of the motion rules.
module tb_trakball_emu;

    localparam int PRESCALE   = 4;
    localparam int SPEED_MAX  = 4;
    localparam int RAMP_TICKS = 2;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       joy_l = 1'b0, joy_r = 1'b0, joy_u = 1'b0, joy_d = 1'b0;
    logic       swap_xy = 1'b0;
    logic       mouse_strobe = 1'b0;
    logic [8:0] mouse_dx = '0, mouse_dy = '0;
    logic [3:0] h_cnt, v_cnt;
    logic       h_dir, v_dir;
    logic [7:0] trakball_o;

    int checks = 0;
    int errors = 0;

    trakball_emu #(
        .PRESCALE  (PRESCALE),
        .SPEED_MAX (SPEED_MAX),
        .RAMP_TICKS(RAMP_TICKS)
    ) u_dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .joy_l       (joy_l),
        .joy_r       (joy_r),
        .joy_u       (joy_u),
        .joy_d       (joy_d),
        .swap_xy     (swap_xy),
        .mouse_strobe(mouse_strobe),
        .mouse_dx    (mouse_dx),
        .mouse_dy    (mouse_dy),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_dir       (h_dir),
        .v_dir       (v_dir),
        .trakball_o  (trakball_o)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference model: index 0 = h, 1 = v.
    int m_pend[2], m_cnt[2], m_dir[2], m_held[2], m_md[2];
    int m_phase, m_ticks;
    bit m_primed, m_prev, m_mv;

    function automatic int clamp(input int s);
        return (s > 511) ? 511 : ((s < -511) ? -511 : s);
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            m_pend[a] = 0; m_cnt[a] = 0; m_dir[a] = 0; m_held[a] = 0; m_md[a] = 0;
        end
        m_phase = 0; m_primed = 0; m_prev = 0; m_mv = 0;
    endtask

    task automatic model_step();
        bit t;
        int jp, jn, mouse, joy, step, sp, dx, dy;
        if (reset) begin
            model_reset();
            return;
        end
        t = (m_phase == PRESCALE - 1);
        m_phase = (m_phase + 1) % PRESCALE;
        if (t) m_ticks++;
        for (int a = 0; a < 2; a++) begin
            if (!swap_xy) begin
                jp = (a == 0) ? int'(joy_r) : int'(joy_d);
                jn = (a == 0) ? int'(joy_l) : int'(joy_u);
            end else begin
                jp = (a == 0) ? int'(joy_u) : int'(joy_r);
                jn = (a == 0) ? int'(joy_d) : int'(joy_l);
            end
            mouse = m_mv ? m_md[a] : 0;
            joy = 0;
            step = 0;
            if (t) begin
                if (jp != jn) begin
                    sp = 1 + m_held[a] / RAMP_TICKS;
                    if (sp > SPEED_MAX) sp = SPEED_MAX;
                    joy = (jp != 0) ? sp : -sp;
                    m_held[a]++;
                end else begin
                    m_held[a] = 0;
                end
                if (m_pend[a] > 0) begin
                    step = 1; m_cnt[a] = (m_cnt[a] + 1) % 16; m_dir[a] = 1;
                end else if (m_pend[a] < 0) begin
                    step = -1; m_cnt[a] = (m_cnt[a] + 15) % 16; m_dir[a] = 0;
                end
            end
            m_pend[a] = clamp(m_pend[a] + mouse + joy - step);
        end
        m_mv = m_primed && (mouse_strobe != m_prev);
        dx = int'($signed(mouse_dx));
        dy = int'($signed(mouse_dy));
        m_md[0] = swap_xy ? -dy : dx;
        m_md[1] = swap_xy ? dx : -dy;
        m_prev = mouse_strobe;
        m_primed = 1;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic run_ticks(input int n);
        int start;
        start = m_ticks;
        for (int g = 0; g < (n + 1) * PRESCALE && (m_ticks - start) < n; g++) cycle();
    endtask

    task automatic send_pkt(input int dx, input int dy);
        mouse_dx = 9'(dx);
        mouse_dy = 9'(dy);
        mouse_strobe = ~mouse_strobe;
    endtask

    function automatic logic [7:0] exp_trak();
        return {m_dir[1] != 0, 3'(m_cnt[1]), m_dir[0] != 0, 3'(m_cnt[0])};
    endfunction

    function automatic int dut_pend(input int a);
        return (a == 0) ? int'($signed(u_dut.u_axis_h.pend_q))
                        : int'($signed(u_dut.u_axis_v.pend_q));
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        mouse_strobe = 1'b1;
        model_reset();
        m_ticks = 0;
        repeat (3) cycle();
        checks++;
        if (trakball_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: trakball_o=%h expected 00", trakball_o);
        end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            checks++;
            if (trakball_o !== 8'h00) begin
                errors++;
                $display("FAIL reset_release cyc %0d: trakball_o=%h expected 00", i, trakball_o);
            end
        end
        checks++;
        if (dut_pend(0) != 0 || dut_pend(1) != 0) begin
            errors++;
            $display("FAIL reset_pending: h=%0d v=%0d expected 0 0", dut_pend(0), dut_pend(1));
        end
    endtask

    task automatic test_mouse_drain();
        int seq[$];
        logic [3:0] last;
        last = h_cnt;
        swap_xy = 1'b0;
        send_pkt(3, 0);
        for (int i = 0; i < 24; i++) begin
            cycle();
            checks++;
            if (trakball_o !== exp_trak() || {v_cnt, h_cnt} !== {4'(m_cnt[1]), 4'(m_cnt[0])}) begin
                errors++;
                $display("FAIL mouse_drain cyc %0d: trak=%h h=%0d v=%0d expected trak=%h h=%0d v=%0d",
                         i, trakball_o, h_cnt, v_cnt, exp_trak(), m_cnt[0], m_cnt[1]);
            end
            if (h_cnt != last) seq.push_back(int'(h_cnt));
            last = h_cnt;
        end
        checks++;
        if (seq.size() != 3 || seq[0] != 1 || seq[1] != 2 || seq[2] != 3 || h_dir !== 1'b1
            || v_cnt !== 4'd0 || v_dir !== 1'b0) begin
            errors++;
            $display("FAIL mouse_drain_seq: steps=%p h_dir=%b v_cnt=%0d expected steps 1,2,3 h_dir=1 v_cnt=0",
                     seq, h_dir, v_cnt);
        end
    endtask

    task automatic test_joy_ramp();
        int exp_c[8] = '{-1, -1, -2, -2, -3, -3, -4, -4};
        int start, prev, idx, got;
        joy_l = 1'b1;
        start = m_ticks;
        idx = 0;
        for (int g = 0; g < 60 && (m_ticks - start) < 8; g++) begin
            prev = dut_pend(0);
            cycle();
            if (m_ticks - start > idx) begin
                got = dut_pend(0) - prev + ((prev > 0) ? 1 : ((prev < 0) ? -1 : 0));
                checks++;
                if (got != exp_c[idx]) begin
                    errors++;
                    $display("FAIL joy_ramp tick %0d: contribution=%0d expected %0d", idx, got, exp_c[idx]);
                end
                idx++;
            end
        end
        checks++;
        if (dut_pend(0) != -13 || h_cnt !== 4'd12 || h_dir !== 1'b0 || m_pend[0] != -13) begin
            errors++;
            $display("FAIL joy_ramp_end: pend=%0d h_cnt=%0d h_dir=%b expected -13 12 0",
                     dut_pend(0), h_cnt, h_dir);
        end
        joy_l = 1'b0;
        run_ticks(2);
        joy_r = 1'b1;
        run_ticks(1);
        joy_r = 1'b0;
        checks++;
        if (dut_pend(0) != -9) begin
            errors++;
            $display("FAIL joy_release_speed: pend=%0d expected -9", dut_pend(0));
        end
        repeat (48) cycle();
        checks++;
        if (trakball_o !== exp_trak() || dut_pend(0) != m_pend[0]) begin
            errors++;
            $display("FAIL joy_drain: trak=%h pend=%0d expected trak=%h pend=%0d",
                     trakball_o, dut_pend(0), exp_trak(), m_pend[0]);
        end
    endtask

    task automatic test_saturation();
        int maxp, p0;
        maxp = -1000;
        joy_r = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_pkt(255, 0);
            cycle();
        end
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (dut_pend(0) > maxp) maxp = dut_pend(0);
            checks++;
            if (dut_pend(0) != m_pend[0] || trakball_o !== exp_trak()) begin
                errors++;
                $display("FAIL sat_track cyc %0d: pend=%0d trak=%h expected pend=%0d trak=%h",
                         i, dut_pend(0), trakball_o, m_pend[0], exp_trak());
            end
        end
        checks++;
        if (maxp != 511) begin
            errors++;
            $display("FAIL sat_clamp: max pending=%0d expected 511", maxp);
        end
        joy_r = 1'b0;
        for (int g = 0; g < PRESCALE && m_phase != PRESCALE - 2; g++) cycle();
        p0 = m_pend[0];
        send_pkt(-5, 0);
        cycle();
        cycle();
        checks++;
        if (dut_pend(0) != p0 - 6) begin
            errors++;
            $display("FAIL same_cycle_tick: pend=%0d expected %0d", dut_pend(0), p0 - 6);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (2) cycle();
        send_pkt(100, 0);
        cycle();
        cycle();
        checks++;
        if (dut_pend(0) != 100) begin
            errors++;
            $display("FAIL reset_mid_setup: pend=%0d expected 100", dut_pend(0));
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (trakball_o !== 8'h00 || dut_pend(0) != 0) begin
            errors++;
            $display("FAIL reset_mid_async: trak=%h pend=%0d expected 00 0", trakball_o, dut_pend(0));
        end
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            checks++;
            if (trakball_o !== 8'h00 || h_cnt !== 4'd0) begin
                errors++;
                $display("FAIL reset_mid_after cyc %0d: trak=%h h_cnt=%0d expected 00 0",
                         i, trakball_o, h_cnt);
            end
        end
    endtask

    task automatic test_rotation();
        swap_xy = 1'b1;
        joy_u = 1'b1;
        run_ticks(3);
        checks++;
        if (h_cnt !== 4'd2 || h_dir !== 1'b1 || v_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rot_up: h_cnt=%0d h_dir=%b v_cnt=%0d expected 2 1 0", h_cnt, h_dir, v_cnt);
        end
        joy_u = 1'b0;
        joy_r = 1'b1;
        run_ticks(3);
        checks++;
        if (v_cnt !== 4'd2 || dut_pend(1) != 2) begin
            errors++;
            $display("FAIL rot_right: v_cnt=%0d pend_v=%0d expected 2 2", v_cnt, dut_pend(1));
        end
        joy_l = 1'b1;
        run_ticks(2);
        checks++;
        if (v_cnt !== 4'd4 || dut_pend(1) != 0) begin
            errors++;
            $display("FAIL rot_conflict: v_cnt=%0d pend_v=%0d expected 4 0", v_cnt, dut_pend(1));
        end
        joy_l = 1'b0;
        run_ticks(1);
        checks++;
        if (dut_pend(1) != 1 || trakball_o !== exp_trak()) begin
            errors++;
            $display("FAIL rot_speed_reset: pend_v=%0d trak=%h expected 1 %h",
                     dut_pend(1), trakball_o, exp_trak());
        end
        joy_r = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if (i % 8 == 0) {joy_l, joy_r, joy_u, joy_d} = 4'($urandom_range(0, 15));
            if (i % 97 == 0) swap_xy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0)
                send_pkt(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);
            cycle();
            checks++;
            if (trakball_o !== exp_trak() || dut_pend(0) != m_pend[0] || dut_pend(1) != m_pend[1]) begin
                errors++;
                $display("FAIL random cyc %0d: trak=%h ph=%0d pv=%0d expected trak=%h ph=%0d pv=%0d",
                         i, trakball_o, dut_pend(0), dut_pend(1), exp_trak(), m_pend[0], m_pend[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mouse_drain();
        test_joy_ramp();
        test_saturation();
        test_reset_mid();
        test_rotation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
